// File: rtl/alu_issue_ctrl.sv
// Issue/writeback front end for a combinational ALU: accepts one instruction word,
// presents registered operands for one EXEC cycle, then writes back result, flags and count.
module alu_issue_ctrl #(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [15:0]              instr,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [3:0]               alu_op,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic [2:0]               alu_flags,
  input  logic [$clog2(NREGS)-1:0] dbg_sel,
  output logic [WIDTH-1:0]         dbg_data,
  output logic [2:0]               flags_q,
  output logic                     done,
  output logic                     err,
  output logic [15:0]              retired_count
);

  localparam int IDXW = $clog2(NREGS);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDI = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd9);
  endfunction

  state_t           state_q, state_d;
  logic [15:0]      instr_q, instr_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [2:0]       flags_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;

  logic [3:0]       op_in;
  logic [IDXW-1:0]  rs1_in, rs2_in;
  logic [3:0]       op_x;
  logic [IDXW-1:0]  rd_x;
  logic [WIDTH-1:0] imm_x;

  assign op_in  = instr[15:12];
  assign rs1_in = instr[8:6];
  assign rs2_in = instr[5:3];
  assign op_x   = instr_q[15:12];
  assign rd_x   = instr_q[11:9];
  assign imm_x  = {{(WIDTH-9){1'b0}}, instr_q[8:0]};

  // Operands are captured at the accept edge; no writeback can land between
  // that edge and EXEC, so they equal the EXEC-cycle register contents.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    regs_d   = regs_q;
    flags_d  = flags_q;
    err_d    = err_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    alu_a_d  = {WIDTH{1'b0}};
    alu_b_d  = {WIDTH{1'b0}};
    alu_op_d = 4'd0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_EXEC;
          if (is_alu_op(op_in)) begin
            alu_a_d  = regs_q[rs1_in];
            alu_b_d  = regs_q[rs2_in];
            alu_op_d = op_in;
          end else begin
            alu_op_d = 4'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        case (op_x)
          OP_NOP: err_d = err_q;
          OP_LDI: regs_d[rd_x] = imm_x;
          default: begin
            if (is_alu_op(op_x)) begin
              regs_d[rd_x] = alu_out;
              flags_d      = alu_flags;
            end else begin
              err_d = 1'b1;
            end
          end
        endcase
        done_d  = 1'b1;
        cnt_d   = cnt_q + 16'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset also aborts an in-flight EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= 16'd0;
      regs_q   <= '{default: {WIDTH{1'b0}}};
      flags_q  <= 3'd0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= 16'd0;
      alu_a_q  <= {WIDTH{1'b0}};
      alu_b_q  <= {WIDTH{1'b0}};
      alu_op_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      regs_q   <= regs_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign instr_ready   = (state_q == ST_IDLE);
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;
  assign dbg_data      = regs_q[dbg_sel];
  assign done          = done_q;
  assign err           = err_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU; flags = {carry/borrow, negative, zero}.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst, instr_valid, instr_ready, done, err;
  logic [15:0] instr, alu_a, alu_b, alu_out, dbg_data, retired_count;
  logic [3:0]  alu_op;
  logic [2:0]  alu_flags, dbg_sel, flags_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.NREGS(8), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flags(alu_flags), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .flags_q(flags_q), .done(done), .err(err), .retired_count(retired_count)
  );

  // Reference ALU the issue stage drives
  always_comb begin
    logic [16:0] t;
    logic        c;
    t = 17'd0;
    c = 1'b0;
    alu_out = 16'd0;
    case (alu_op)
      4'd1: begin t = {1'b0, alu_a} + {1'b0, alu_b}; alu_out = t[15:0]; c = t[16]; end
      4'd2: begin alu_out = alu_a - alu_b; c = (alu_a < alu_b); end
      4'd3: alu_out = alu_a * alu_b;
      4'd4: alu_out = (alu_b == 16'd0) ? 16'hFFFF : alu_a / alu_b;
      4'd5: alu_out = alu_a | alu_b;
      4'd6: alu_out = alu_a & alu_b;
      4'd7: alu_out = ~alu_a;
      4'd8: alu_out = alu_a ^ alu_b;
      4'd9: alu_out = {15'd0, (alu_a < alu_b)};
      default: alu_out = 16'd0;
    endcase
    alu_flags = {c, alu_out[15], (alu_out == 16'd0)};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one word; returns at the done cycle (#1 after writeback edge) with the rd value seen in EXEC.
  task automatic issue(input logic [15:0] w, output logic [15:0] exec_dbg);
    int n;
    logic [3:0] exp_op;
    exp_op = ((w[15:12] >= 4'd1) && (w[15:12] <= 4'd9)) ? w[15:12] : 4'd0;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 16'hFFFF;
    dbg_sel = w[11:9];
    #1;
    exec_dbg = dbg_data;
    check("exec_ready", {31'd0, instr_ready}, 32'd0);
    check("exec_op", {28'd0, alu_op}, {28'd0, exp_op});
    @(posedge clk);
    #1;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("idle_op", {28'd0, alu_op}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] w;
    logic [2:0]  rd;
    logic [15:0] val;
    logic [2:0]  flg;
    logic        er;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[16];
  logic [15:0] words[4];
  logic [15:0] xd;
  logic        rdy[8];
  int          dcount, k;

  initial begin
    vecs[0]  = '{16'hA203, 3'd1, 16'h0003, 3'b000, 1'b0, 16'd1};  // LDI r1,3
    vecs[1]  = '{16'hA5FF, 3'd2, 16'h01FF, 3'b000, 1'b0, 16'd2};  // LDI r2,511
    vecs[2]  = '{16'h1650, 3'd3, 16'h0202, 3'b000, 1'b0, 16'd3};  // ADD r3,r1,r2
    vecs[3]  = '{16'h2850, 3'd4, 16'hFE04, 3'b110, 1'b0, 16'd4};  // SUB r4,r1,r2
    vecs[4]  = '{16'h3A50, 3'd5, 16'h05FD, 3'b000, 1'b0, 16'd5};  // MUL r5,r1,r2
    vecs[5]  = '{16'h7C80, 3'd6, 16'hFE00, 3'b010, 1'b0, 16'd6};  // NOT r6,r2
    vecs[6]  = '{16'h1F20, 3'd7, 16'hFC08, 3'b110, 1'b0, 16'd7};  // ADD r7,r4,r4
    vecs[7]  = '{16'h80D8, 3'd0, 16'h0000, 3'b001, 1'b0, 16'd8};  // XOR r0,r3,r3
    vecs[8]  = '{16'h0000, 3'd0, 16'h0000, 3'b001, 1'b0, 16'd9};  // NOP
    vecs[9]  = '{16'hC250, 3'd1, 16'h0003, 3'b001, 1'b1, 16'd10}; // illegal op 12
    vecs[10] = '{16'h1250, 3'd1, 16'h0202, 3'b000, 1'b1, 16'd11}; // ADD r1,r1,r2
    vecs[11] = '{16'h44C8, 3'd2, 16'h0001, 3'b000, 1'b1, 16'd12}; // DIV r2,r3,r1
    vecs[12] = '{16'h5708, 3'd3, 16'hFE06, 3'b010, 1'b1, 16'd13}; // OR r3,r4,r1
    vecs[13] = '{16'h6B18, 3'd5, 16'hFE04, 3'b010, 1'b1, 16'd14}; // AND r5,r4,r3
    vecs[14] = '{16'h9C60, 3'd6, 16'h0001, 3'b000, 1'b1, 16'd15}; // CMP r6,r1,r4
    vecs[15] = '{16'hAF00, 3'd7, 16'h0100, 3'b000, 1'b1, 16'd16}; // LDI r7,0x100
    words[0] = 16'h1090; // ADD r0,r2,r2 -> 2
    words[1] = 16'h2FC0; // SUB r7,r7,r0 -> 0xFE
    words[2] = 16'hA4AA; // LDI r2,0xAA
    words[3] = 16'h8DD0; // XOR r6,r7,r2 -> 0x54

    rst = 1'b1; instr_valid = 1'b0; instr = 16'd0; dbg_sel = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cnt", {16'd0, retired_count}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_flags", {29'd0, flags_q}, 32'd0);
    check("rst_alu", {alu_a, 12'd0, alu_op}, 32'd0);
    for (int r = 0; r < 8; r++) begin
      dbg_sel = 3'(r);
      #1;
      check($sformatf("rst_reg%0d", r), {16'd0, dbg_data}, 32'd0);
    end

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].w, xd);
      dbg_sel = vecs[i].rd;
      #1;
      check($sformatf("v%0d_reg", i), {16'd0, dbg_data}, {16'd0, vecs[i].val});
      check($sformatf("v%0d_flags", i), {29'd0, flags_q}, {29'd0, vecs[i].flg});
      check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].er});
      check($sformatf("v%0d_cnt", i), {16'd0, retired_count}, {16'd0, vecs[i].cnt});
    end

    // Back-to-back issue with instr_valid held high
    @(posedge clk);
    #1;
    check("pre_b2b_done", {31'd0, done}, 32'd0);
    instr_valid = 1'b1;
    dcount = 0;
    k = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i > 0) dcount += int'(done);
      if (i < 8) begin
        rdy[i] = instr_ready;
        if (instr_ready && k < 4) begin
          instr = words[k];
          k++;
        end
      end else begin
        instr_valid = 1'b0;
      end
    end
    for (int i = 0; i < 8; i++)
      check($sformatf("b2b_ready%0d", i), {31'd0, rdy[i]}, {31'd0, ((i % 2) == 0)});
    check("b2b_dones", dcount, 32'd4);
    dbg_sel = 3'd0; #1; check("b2b_r0", {16'd0, dbg_data}, 32'h0002);
    dbg_sel = 3'd7; #1; check("b2b_r7", {16'd0, dbg_data}, 32'h00FE);
    dbg_sel = 3'd2; #1; check("b2b_r2", {16'd0, dbg_data}, 32'h00AA);
    dbg_sel = 3'd6; #1; check("b2b_r6", {16'd0, dbg_data}, 32'h0054);
    check("b2b_cnt", {16'd0, retired_count}, 32'd20);

    // Reset during EXEC of ADD r5,r1,r2 aborts it
    @(negedge clk);
    instr = 16'h1A50;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("abort_exec_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    dbg_sel = 3'd5;
    #1;
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_ready", {31'd0, instr_ready}, 32'd1);
    check("abort_cnt", {16'd0, retired_count}, 32'd0);
    check("abort_r5", {16'd0, dbg_data}, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    check("abort_no_done", {31'd0, done}, 32'd0);

    // Counter wrap and NOT with pre-write debug view
    issue(16'hA5FF, xd);
    check("wrap_cnt1", {16'd0, retired_count}, 32'd1);
    @(negedge clk);
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    issue(16'h7C80, xd);
    check("not_prewrite", {16'd0, xd}, 32'd0);
    dbg_sel = 3'd6;
    #1;
    check("not_r6", {16'd0, dbg_data}, 32'hFE00);
    check("not_flags", {29'd0, flags_q}, 32'd2);
    check("cnt_ffff", {16'd0, retired_count}, 32'hFFFF);
    issue(16'h0000, xd);
    check("cnt_wrap", {16'd0, retired_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Instruction issue/writeback stage that sits directly upstream of the ALU.
- Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives the ALU operand and opcode inputs, then captures the ALU result and 3-bit flags into the destination register and a flags register.
- Gives the combinational ALU a sequential front end: register state, sequencing and a retire counter.

Parameters:
- NREGS, 8, register-file depth; register index width is log2(NREGS) = 3.
- WIDTH, 16, datapath width; must match the ALU operand width.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction word present
- instr_ready  out  1  block can accept an instruction this cycle
- instr  in  16  [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [8:0] imm9 (LDI only)
- alu_a  out  16  ALU operand A
- alu_b  out  16  ALU operand B
- alu_op  out  4  ALU opcode
- alu_out  in  16  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_flags  in  3  ALU flags
- dbg_sel  in  3  debug register select
- dbg_data  out  16  combinational read of reg[dbg_sel]
- flags_q  out  3  flags from the last ALU instruction
- done  out  1  one-cycle pulse per retired instruction
- err  out  1  sticky illegal-opcode flag
- retired_count  out  16  retired-instruction counter; wraps 0xFFFF -> 0

Behaviour:
- Reset: state=IDLE; all registers, flags_q, err and retired_count cleared to 0; done=0; alu_a, alu_b and alu_op = 0.
- Reset during EXEC aborts the instruction: no writeback and no done pulse.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 MUL (low 16 bits), 4 DIV, 5 OR, 6 AND, 7 NOT (operand A only), 8 XOR, 9 CMP
  - 10 LDI: rd <= zero-extended imm9
  - 11-15 illegal
- FSM:
  - IDLE: instr_ready=1. On instr_valid at a rising edge, latch instr into instr_q and go to EXEC.
  - EXEC: instr_ready=0.
    - For opcodes 1-9: alu_a=reg[rs1], alu_b=reg[rs2], alu_op=opcode.
    - Otherwise alu_a, alu_b and alu_op are driven to 0.
    - At the end-of-EXEC edge:
      - opcodes 1-9: reg[rd]<=alu_out, flags_q<=alu_flags
      - LDI: reg[rd]<=imm9, flags_q unchanged
      - NOP: no write
      - illegal: no write, err<=1
    - In every case: done<=1, retired_count+=1, go to IDLE.
- Latency: accepted at edge N, writeback at edge N+1, done high during the cycle after N+1.
- Throughput: one instruction per 2 cycles. Holding instr_valid high accepts a new word on every IDLE edge.
- done is high in the IDLE cycle following writeback. A new instruction may be accepted on the same edge that ends the done cycle.
- In IDLE, alu_a, alu_b and alu_op are forced to 0 so the ALU sees opcode 0.
- rd may equal rs1/rs2. Operands are read before the write, so the old value is used.
- dbg_data shows the pre-write value during the EXEC cycle and the new value from the following cycle on.
- instr changing while in EXEC has no effect; only instr_q is used.
- err stays 1 until rst; later instructions still execute normally.
- retired_count counts NOP and illegal instructions too.

Test Plan:
- Setup for all scenarios: drive the real alu instance from alu_a/alu_b/alu_op.
1. rst, then LDI r1,3; LDI r2,511 -> reg1=0x0003, reg2=0x01FF; two done pulses; retired_count=2; flags_q=0.
2. ADD r3,r1,r2 -> reg3=514. SUB r4,r1,r2 -> reg4=0xFE04 (-508). flags_q equals alu_flags sampled during each EXEC cycle.
3. instr_valid held high with 4 queued words -> instr_ready toggles 1,0,1,0. Exactly 4 done pulses in 8 cycles. Values match a sequential software model.
4. Opcode 12 word -> err=1, no register changes, done pulses, retired_count increments. A following ADD still writes correctly and err stays 1.
5. Assert rst in the EXEC cycle of ADD r5,r1,r2 -> reg5=0, no done, retired_count=0, state IDLE with instr_ready=1 next cycle.
6. Preload retired_count near wrap (issue 65535 NOPs, or force) -> one more instruction gives retired_count=0. NOT r6,r2 -> reg6=0xFE00.
